// File: rtl/alu_bus_controller.sv
// Requesting-side sequencer for the 4-bit arithmetic unit: latches an add/sub request,
// holds EnableAlu for SETTLE_CYCLES, captures IB_Alu/Carry. Optional macro: ALU_ACCUMULATE_EN.
//
// state  | meaning
// IDLE   | Ready=1, waiting for Start
// SETUP  | operands driven and stable, EnableAlu still low
// SETTLE | EnableAlu high, settle counter runs down to zero
// DONE   | Result/flags updated, one-cycle Done pulse
module alu_bus_controller #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Start,
    input  logic       Op,
    input  logic [3:0] OpA,
    input  logic [3:0] OpB,
    input  logic       Abort,
`ifdef ALU_ACCUMULATE_EN
    input  logic       AccMode,
`endif
    output logic       Ready,
    output logic       Done,
    output logic [3:0] Result,
    output logic       CarryFlag,
    output logic       ZeroFlag,
    output logic       OverflowFlag,
    output logic [3:0] AluA,
    output logic [3:0] AluB,
    output logic       AddSub,
    output logic       EnableAlu,
    input  logic [3:0] IB_Alu,
    input  logic       AluCarry
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             start_ok;
    logic             abort_ok;
    logic             cnt_tc;
    logic             capture;
    logic             ready_d;
    logic             enable_d;
    logic             done_d;
    logic             ovf_d;
    logic [3:0]       b_src;

    assign start_ok = (state_q == S_IDLE) && Start;
    assign abort_ok = Abort && ((state_q == S_SETUP) || (state_q == S_SETTLE));
    assign cnt_tc   = (cnt_q == '0);
    assign capture  = (state_q == S_SETTLE) && cnt_tc && !Abort;

`ifdef ALU_ACCUMULATE_EN
    assign b_src = AccMode ? Result : OpB;
`else
    assign b_src = OpB;
`endif

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = Abort ? S_IDLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else if (cnt_tc) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered, so they are decoded from the next state.
    always_comb begin
        ready_d  = 1'b0;
        enable_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            S_IDLE:   ready_d  = 1'b1;
            S_SETTLE: enable_d = 1'b1;
            S_DONE:   done_d   = 1'b1;
            default:  ready_d  = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Ready     <= 1'b1;
            EnableAlu <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Ready     <= ready_d;
            EnableAlu <= enable_d;
            Done      <= done_d;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else if (state_q == S_SETUP) begin
            cnt_q <= CNT_LOAD;
        end else if ((state_q == S_SETTLE) && !cnt_tc && !abort_ok) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // Operand lines only move on an accepted Start, so they are frozen while EnableAlu is high.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            AluA   <= 4'h0;
            AluB   <= 4'h0;
            AddSub <= 1'b0;
        end else if (start_ok) begin
            AluA   <= OpA;
            AluB   <= b_src;
            AddSub <= Op;
        end
    end

    // Sub is B-A, so signed overflow compares against B's sign instead of A's.
    always_comb begin
        if (AddSub) begin
            ovf_d = (AluA[3] != AluB[3]) && (IB_Alu[3] != AluB[3]);
        end else begin
            ovf_d = (AluA[3] == AluB[3]) && (IB_Alu[3] != AluA[3]);
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Result       <= 4'h0;
            CarryFlag    <= 1'b0;
            ZeroFlag     <= 1'b0;
            OverflowFlag <= 1'b0;
        end else if (capture) begin
            Result       <= IB_Alu;
            CarryFlag    <= AluCarry;
            ZeroFlag     <= (IB_Alu == 4'h0);
            OverflowFlag <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_bus_controller.sv
// Bench for alu_bus_controller: models the arithmetic unit on the bus, checks a vector
// table, abort/reset sequences and random operations against an integer reference model.
module tb_alu_bus_controller;

    localparam int SETTLE = 2;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic       Start = 1'b0;
    logic       Op = 1'b0;
    logic [3:0] OpA = 4'h0;
    logic [3:0] OpB = 4'h0;
    logic       Abort = 1'b0;
`ifdef ALU_ACCUMULATE_EN
    logic       AccMode = 1'b0;
`endif
    logic       Ready, Done, CarryFlag, ZeroFlag, OverflowFlag, AddSub, EnableAlu;
    logic [3:0] Result, AluA, AluB;
    logic [3:0] IB_Alu;
    logic       AluCarry;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] model_result = 4'h0;

    alu_bus_controller #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .Abort(Abort),
`ifdef ALU_ACCUMULATE_EN
        .AccMode(AccMode),
`endif
        .Ready(Ready), .Done(Done), .Result(Result), .CarryFlag(CarryFlag),
        .ZeroFlag(ZeroFlag), .OverflowFlag(OverflowFlag), .AluA(AluA), .AluB(AluB),
        .AddSub(AddSub), .EnableAlu(EnableAlu), .IB_Alu(IB_Alu), .AluCarry(AluCarry)
    );

    always #5 Clk = ~Clk;

    // Arithmetic unit: bus only carries the true value in the last settle cycle.
    int en_cnt;
    logic [4:0] alu_sum;
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)        en_cnt <= 0;
        else if (EnableAlu) en_cnt <= en_cnt + 1;
        else                en_cnt <= 0;
    end
    always_comb begin
        alu_sum = AddSub ? ({1'b0, AluB} + {1'b0, ~AluA} + 5'd1) : ({1'b0, AluB} + {1'b0, AluA});
        if (EnableAlu && en_cnt == SETTLE - 1) begin
            IB_Alu   = alu_sum[3:0];
            AluCarry = alu_sum[4];
        end else begin
            IB_Alu   = ~alu_sum[3:0];
            AluCarry = ~alu_sum[4];
        end
    end

    typedef struct {
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       c;
        logic       z;
        logic       v;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, zero, carry, result} from plain integer arithmetic.
    function automatic logic [6:0] ref_alu(input logic op, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, raw, sres;
        logic [3:0] r;
        logic c;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        if (!op) begin
            raw  = ub + ua;
            c    = (raw > 15);
            sres = sb + sa;
        end else begin
            raw  = ub - ua;
            c    = (ub >= ua);
            sres = sb - sa;
        end
        r = raw[3:0];
        return {(sres < -8 || sres > 7), (r == 4'h0), c, r};
    endfunction

    task automatic run_op(input logic op, input logic [3:0] a, input logic [3:0] b, input logic acc,
                          input logic with_abort,
                          input logic [3:0] er, input logic ec, input logic ez, input logic ev);
        int en_cycles;
        int done_at;
        int unstable;
        logic [3:0] b_eff;
        b_eff = acc ? model_result : b;
        Start = 1'b1; Op = op; OpA = a; OpB = b; Abort = with_abort;
`ifdef ALU_ACCUMULATE_EN
        AccMode = acc;
`endif
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0; OpA = ~a; OpB = ~b; Op = ~op;
        check("ready_busy", int'(Ready), 0);
        en_cycles = 0; done_at = -1; unstable = 0;
        for (int j = 0; j < SETTLE + 6 && done_at < 0; j++) begin
            if (j > 0) @(negedge Clk);
            if (EnableAlu) begin
                en_cycles++;
                if (AluA != a || AluB != b_eff || AddSub != op) unstable++;
            end
            if (Done) done_at = j;
        end
        check("done_latency", done_at, SETTLE + 1);
        check("enable_cycles", en_cycles, SETTLE);
        check("operands_stable", unstable, 0);
        check("result", int'(Result), int'(er));
        check("carry", int'(CarryFlag), int'(ec));
        check("zero", int'(ZeroFlag), int'(ez));
        check("overflow", int'(OverflowFlag), int'(ev));
        model_result = er;
        @(negedge Clk);
        check("done_pulse", int'(Done), 0);
        check("ready_back", int'(Ready), 1);
        check("alua_hold", int'(AluA), int'(a));
    endtask

    vec_t vecs[6];

    initial begin
        logic [6:0] e;
        logic [3:0] ra, rb, rbe;
        logic rop, racc;
        int seen_done;

        vecs[0] = '{1'b0, 4'h5, 4'h3, 4'h8, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 4'h5, 4'h3, 4'hE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 4'h9, 4'h7, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 4'h1, 4'h8, 4'h7, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge Clk);
        check("rst_ready", int'(Ready), 1);
        check("rst_enable", int'(EnableAlu), 0);
        check("rst_result", int'(Result), 0);
        check("rst_flags", int'({CarryFlag, ZeroFlag, OverflowFlag, Done}), 0);
        nReset = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0,
                   vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].v);
        end

        // Abort in the capture cycle; a held Start with new operands must be ignored.
        Start = 1'b1; Op = 1'b0; OpA = 4'h1; OpB = 4'h1;
        @(negedge Clk);
        OpA = 4'h7;
        seen_done = 0;
        @(negedge Clk);
        seen_done += int'(Done);
        @(negedge Clk);
        seen_done += int'(Done);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0; Start = 1'b0;
        seen_done += int'(Done);
        check("abort_enable", int'(EnableAlu), 0);
        check("abort_ready", int'(Ready), 1);
        check("abort_result", int'(Result), int'(model_result));
        check("busy_start_ignored", int'(AluA), 1);
        @(negedge Clk);
        seen_done += int'(Done);
        check("abort_no_done", seen_done, 0);
        check("abort_idle", int'(Ready), 1);

        // Reset mid-settle.
        Start = 1'b1; Op = 1'b1; OpA = 4'h2; OpB = 4'h6;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        check("pre_rst_enable", int'(EnableAlu), 1);
        #1 nReset = 1'b0;
        #1;
        check("midrst_enable", int'(EnableAlu), 0);
        check("midrst_ready", int'(Ready), 1);
        check("midrst_result", int'(Result), 0);
        check("midrst_ops", int'({AluA, AluB, AddSub}), 0);
        check("midrst_flags", int'({CarryFlag, ZeroFlag, OverflowFlag, Done}), 0);
        model_result = 4'h0;
        @(negedge Clk);
        nReset = 1'b1;
        @(negedge Clk);
        run_op(1'b1, 4'h2, 4'h6, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0);

        // Start and Abort together in IDLE: Start wins.
        run_op(1'b0, 4'h4, 4'h4, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
`ifdef ALU_ACCUMULATE_EN
            racc = 1'($urandom_range(0, 1));
`else
            racc = 1'b0;
`endif
            rbe = racc ? model_result : rb;
            e = ref_alu(rop, ra, rbe);
            run_op(rop, ra, rb, racc, 1'b0, e[3:0], e[4], e[5], e[6]);
        end

`ifdef ALU_ACCUMULATE_EN
        run_op(1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 4'h3, 4'hC, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 4'h4, 4'hC, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_bus_controller.md
Name: alu_bus_controller

Overview:
- Sequencer on the requesting side of the 4-bit arithmetic unit's internal-bus interface.
- Accepts an add/sub request through a Start/Ready handshake, then drives the operand lines and AddSub into the arithmetic unit.
- Asserts EnableAlu for a programmable settle window, samples IB_Alu and Carry, and presents a registered result with flags and a one-cycle Done pulse.

Parameters:
- SETTLE_CYCLES, 2: cycles EnableAlu is held before IB_Alu/Carry are sampled. Legal range 1..15.
- CNT_W, 4: width of the settle counter. Must hold SETTLE_CYCLES.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- Start  input  1  request; accepted only when Ready=1.
- Op  input  1  0=add (B+A), 1=subtract (B-A).
- OpA  input  4  operand A.
- OpB  input  4  operand B.
- Abort  input  1  synchronous cancel of an in-flight operation.
- Ready  output  1  controller idle; can accept Start.
- Done  output  1  one-cycle pulse when Result and the flags update.
- Result  output  4  registered ALU result.
- CarryFlag  output  1  captured Carry (for sub: 1 = no borrow).
- ZeroFlag  output  1  Result==0.
- OverflowFlag  output  1  signed two's-complement overflow.
- AluA  output  4  to arithmetic unit A3..A0.
- AluB  output  4  to arithmetic unit B3..B0.
- AddSub  output  1  to arithmetic unit; equals latched Op.
- EnableAlu  output  1  to arithmetic unit; gates its tristate bus drivers.
- IB_Alu  input  4  internal bus, driven by the arithmetic unit.
- AluCarry  input  1  Carry from the arithmetic unit.

Behaviour:
- Reset: nReset low asynchronously forces state IDLE. Ready=1; Done, EnableAlu, AddSub, AluA, AluB, Result and all flags = 0. This applies in any state, including mid-SETTLE; EnableAlu drops immediately.
- State IDLE: Ready=1, EnableAlu=0.
  - On Start=1, latch OpA→AluA, OpB→AluB, Op→AddSub; go to SETUP. Ready=0 from the next cycle.
- State SETUP: operands stable, EnableAlu=0. Load counter=SETTLE_CYCLES-1; go to SETTLE.
- State SETTLE: EnableAlu=1.
  - When counter≠0, decrement it.
  - When counter==0, on that edge capture IB_Alu→Result and AluCarry→CarryFlag, compute the flags, go to DONE.
- State DONE: Done=1 for exactly one cycle, EnableAlu=0, Ready=0; go to IDLE.
- Latency: Start accepted at edge 0; Done high in cycle 2+SETTLE_CYCLES. Ready returns the cycle after Done.
- AluA/AluB/AddSub hold their values after completion until the next accepted Start. They never change while EnableAlu=1.
- Abort=1 in SETUP or SETTLE: go to IDLE next edge, EnableAlu=0, no Done, Result and flags unchanged.
  - Abort in IDLE or DONE is ignored; DONE still pulses.
  - Abort and Start together in IDLE: Start wins.
- Start while Ready=0 is ignored; no queueing.
- ZeroFlag = (captured Result==4'h0).
- OverflowFlag:
  - add: A[3]==B[3] and R[3]≠A[3].
  - sub (B-A): A[3]≠B[3] and R[3]≠B[3].
- Flags update only on a capture edge. Every output is registered.

Optional Feature:
- Macro ALU_ACCUMULATE_EN.
- Defined: adds input AccMode (1 bit).
  - When AccMode=1 at Start acceptance, AluB is loaded from the current Result instead of OpB. This gives running sums and differences.
  - AccMode is ignored when Ready=0.
- Not defined: port absent; AluB always loaded from OpB.

Test Plan:
- Reset → Ready=1, EnableAlu=0, Result=0, all flags 0. Start Op=0, A=5, B=3, SETTLE_CYCLES=2, model returns 8 → Done in cycle 4, Result=4'h8, CarryFlag=0, ZeroFlag=0, OverflowFlag=1.
- Op=1, A=5, B=3, model returns B-A → Result=4'hE, CarryFlag=0, OverflowFlag=0, ZeroFlag=0. Check AddSub=1 during SETTLE.
- Op=0, A=9, B=7 → Result=4'h0, CarryFlag=1, ZeroFlag=1, OverflowFlag=0. Check EnableAlu high exactly SETTLE_CYCLES cycles.
- Abort asserted in the 2nd SETTLE cycle (SETTLE_CYCLES=3) → EnableAlu=0 next cycle, no Done, Result keeps its previous value, Ready=1. Start held during busy cycles is not accepted.
- nReset pulsed low mid-SETTLE → EnableAlu drops asynchronously, all outputs return to reset values. A following Start runs normally.
- ALU_ACCUMULATE_EN: Result=4'h2, Start AccMode=1, Op=0, A=3 → AluB=2, Result=4'h5. A second AccMode add with A=4 → Result=4'h9, OverflowFlag=1.
